sri_slave_rx_sync: RTL and testbench

- Parametrised successor of the serial-in slave receiver.
- Oversamples the serial interface (sclk, mosi, load) in the system clock domain.
- Supports all four SPI clock modes, MSB- or LSB-first order and any word width.
- Checks frame length, then presents each complete word to the host logic through a valid/ack handshake with overrun detection.

---
 rtl/sri_slave_rx_sync_if.sv | 29 ++
 rtl/sri_slave_rx_sync.sv | 157 +++++++++++++++
 tb/tb_sri_slave_rx_sync.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sri_slave_rx_sync_if.sv
// Serial receiver bus: serial pins from the master plus the word handshake
// towards the host logic. N must match the receiver's word width.
interface sri_slave_rx_sync_if #(
  parameter int N = 64
);
  localparam int CW = $clog2(N + 2);

  logic          sclk;
  logic          mosi;
  logic          load;
  logic          do_ack;
  logic [N-1:0]  do_data;
  logic          do_valid;
  logic          frame_err;
  logic          overrun;
  logic [CW-1:0] bit_cnt;

  // Receiver side
  modport slave (
    input  sclk, mosi, load, do_ack,
    output do_data, do_valid, frame_err, overrun, bit_cnt
  );

  // Driver / host side
  modport master (
    output sclk, mosi, load, do_ack,
    input  do_data, do_valid, frame_err, overrun, bit_cnt
  );
endinterface

// File: rtl/sri_slave_rx_sync.sv
// Oversampling serial-in slave receiver. sclk/mosi/load are synchronised into
// clk, sclk edges shift mosi into a word, and the rising edge of load commits
// the frame: a frame of exactly N bits is handed to the host via valid/ack,
// any other length raises a one-cycle frame_err.
module sri_slave_rx_sync #(
  parameter int N           = 64,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sri_slave_rx_sync_if.slave    bus
);
  localparam int         CW          = $clog2(N + 2);
  localparam logic       SAMPLE_RISE = (CPOL == CPHA);
  // Lane order {load, mosi, sclk}; sclk lane idles at CPOL so reset never
  // fabricates an edge.
  localparam logic [2:0] SYNC_RST    = {2'b00, (CPOL != 0)};

  typedef enum logic {IDLE, RECV} state_t;

  // Synchroniser chain, all three lanes travel together so mosi and sclk
  // keep identical latency.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic [2:0] stage_reg;
      if (gi == 0) begin : g_first
        // First stage captures the asynchronous pins
        always_ff @(posedge clk or posedge rst)
          if (rst) stage_reg <= SYNC_RST;
          else     stage_reg <= {bus.load, bus.mosi, bus.sclk};
      end else begin : g_next
        // Further stages resolve metastability
        always_ff @(posedge clk or posedge rst)
          if (rst) stage_reg <= SYNC_RST;
          else     stage_reg <= g_sync[gi-1].stage_reg;
      end
    end
  endgenerate

  logic [2:0] sync_out;
  logic       sclk_s, mosi_s, load_s;
  assign sync_out = g_sync[SYNC_STAGES-1].stage_reg;
  assign load_s   = sync_out[2];
  assign mosi_s   = sync_out[1];
  assign sclk_s   = sync_out[0];

  logic sclk_prev_reg, load_prev_reg;
  logic sample_pls_reg, commit_pls_reg, bit_reg;

  // Edge detection: registered sample/commit pulses with the matching mosi bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_prev_reg  <= (CPOL != 0);
      load_prev_reg  <= 1'b0;
      sample_pls_reg <= 1'b0;
      commit_pls_reg <= 1'b0;
      bit_reg        <= 1'b0;
    end else begin
      sclk_prev_reg  <= sclk_s;
      load_prev_reg  <= load_s;
      sample_pls_reg <= SAMPLE_RISE ? (sclk_s & ~sclk_prev_reg)
                                    : (~sclk_s & sclk_prev_reg);
      commit_pls_reg <= load_s & ~load_prev_reg;
      bit_reg        <= mosi_s;
    end

  state_t        state_reg, state_next;
  logic [N-1:0]  sr_reg, sr_next, sr_shift;
  logic [CW-1:0] cnt_reg, cnt_next, cnt_shift;
  logic          commit_reg, commit_next;
  logic          good_reg, good_next;
  logic [N-1:0]  cdata_reg, cdata_next;

  // Shifted word and saturating count if the current cycle samples a bit
  always_comb begin
    sr_shift  = (MSB_FIRST != 0) ? {sr_reg[N-2:0], bit_reg}
                                 : {bit_reg, sr_reg[N-1:1]};
    cnt_shift = (cnt_reg == CW'(N + 1)) ? cnt_reg : cnt_reg + 1'b1;
  end

  // Frame FSM next state; a bit sampled in the commit cycle joins the frame
  always_comb begin
    state_next  = state_reg;
    sr_next     = sr_reg;
    cnt_next    = cnt_reg;
    commit_next = 1'b0;
    good_next   = 1'b0;
    cdata_next  = sr_reg;
    if (sample_pls_reg) begin
      sr_next    = sr_shift;
      cnt_next   = cnt_shift;
      state_next = RECV;
    end
    if (commit_pls_reg) begin
      commit_next = 1'b1;
      good_next   = (cnt_next == CW'(N));
      cdata_next  = sr_next;
      state_next  = IDLE;
      sr_next     = '0;
      cnt_next    = '0;
    end
  end

  // Frame FSM state, shift register, count and staged commit request
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_reg  <= IDLE;
      sr_reg     <= '0;
      cnt_reg    <= '0;
      commit_reg <= 1'b0;
      good_reg   <= 1'b0;
      cdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      sr_reg     <= sr_next;
      cnt_reg    <= cnt_next;
      commit_reg <= commit_next;
      good_reg   <= good_next;
      cdata_reg  <= cdata_next;
    end

  logic [N-1:0] do_data_reg;
  logic         do_valid_reg, frame_err_reg, overrun_reg;

  // Host handshake: ack consumes, a good commit (re)loads, a bad one flags
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      do_data_reg   <= '0;
      do_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      if (do_valid_reg && bus.do_ack)
        do_valid_reg <= 1'b0;
      if (commit_reg) begin
        if (good_reg) begin
          do_data_reg  <= cdata_reg;
          do_valid_reg <= 1'b1;
          if (do_valid_reg && !bus.do_ack)
            overrun_reg <= 1'b1;
        end else begin
          frame_err_reg <= 1'b1;
        end
      end
    end

  assign bus.do_data   = do_data_reg;
  assign bus.do_valid  = do_valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.overrun   = overrun_reg;
  assign bus.bit_cnt   = cnt_reg;
endmodule

// File: tb/tb_sri_slave_rx_sync.sv
// Directed bench: a mode-0 MSB-first 8-bit receiver plus three 64-bit
// LSB-first receivers in modes 3, 1 and 2 sharing mosi/load.
module tb_sri_slave_rx_sync;
  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       mosi  = 1'b0;
  logic       load  = 1'b0;
  logic       ack8  = 1'b0;
  logic       ack64 = 1'b0;
  logic [3:0] sclk_drv   = 4'b1010;
  logic [3:0] idle_lvl   = 4'b1010;  // CPOL of each receiver
  logic [3:0] sample_lvl = 4'b0011;  // level reached by the sampling edge

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt [4];

  always #5 clk = ~clk;

  sri_slave_rx_sync_if #(.N(8))  ifa ();
  sri_slave_rx_sync_if #(.N(64)) ifb ();
  sri_slave_rx_sync_if #(.N(64)) ifc ();
  sri_slave_rx_sync_if #(.N(64)) ifd ();

  assign ifa.sclk = sclk_drv[0];
  assign ifb.sclk = sclk_drv[1];
  assign ifc.sclk = sclk_drv[2];
  assign ifd.sclk = sclk_drv[3];
  assign ifa.mosi = mosi;
  assign ifb.mosi = mosi;
  assign ifc.mosi = mosi;
  assign ifd.mosi = mosi;
  assign ifa.load = load;
  assign ifb.load = load;
  assign ifc.load = load;
  assign ifd.load = load;
  assign ifa.do_ack = ack8;
  assign ifb.do_ack = ack64;
  assign ifc.do_ack = ack64;
  assign ifd.do_ack = ack64;

  sri_slave_rx_sync #(.N(8),  .CPOL(0), .CPHA(0), .MSB_FIRST(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  sri_slave_rx_sync #(.N(64), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  sri_slave_rx_sync #(.N(64), .CPOL(0), .CPHA(1), .MSB_FIRST(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));
  sri_slave_rx_sync #(.N(64), .CPOL(1), .CPHA(0), .MSB_FIRST(0)) dut_d (.clk(clk), .rst(rst), .bus(ifd));

  // Count clk cycles with frame_err high, per receiver
  always @(negedge clk) begin
    if (ifa.frame_err) fe_cnt[0]++;
    if (ifb.frame_err) fe_cnt[1]++;
    if (ifc.frame_err) fe_cnt[2]++;
    if (ifd.frame_err) fe_cnt[3]++;
  end

  typedef struct {
    int           d;
    logic [127:0] word;
    int           nbits;
    logic         ack_after;
    logic [6:0]   exp_cnt;
    logic [127:0] exp_data;
    logic         exp_valid;
    logic         exp_ovr;
    int           exp_fe;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic read_out(input int d, output logic [127:0] data, output logic v,
                          output logic o, output logic [6:0] cnt);
    data = '0; v = 1'b0; o = 1'b0; cnt = '0;
    case (d)
      0: begin data = 128'(ifa.do_data); v = ifa.do_valid; o = ifa.overrun; cnt = 7'(ifa.bit_cnt); end
      1: begin data = 128'(ifb.do_data); v = ifb.do_valid; o = ifb.overrun; cnt = 7'(ifb.bit_cnt); end
      2: begin data = 128'(ifc.do_data); v = ifc.do_valid; o = ifc.overrun; cnt = 7'(ifc.bit_cnt); end
      default: begin data = 128'(ifd.do_data); v = ifd.do_valid; o = ifd.overrun; cnt = 7'(ifd.bit_cnt); end
    endcase
  endtask

  // Shift nbits of word into receiver d (MSB-first for d=0, LSB-first otherwise)
  task automatic send_word(input int d, input logic [127:0] word, input int nbits);
    int   idx;
    logic b;
    for (int i = 0; i < nbits; i++) begin
      idx = (d == 0) ? (7 - i) : i;
      b = 1'b0;
      if (idx >= 0 && idx < 128) b = word[idx];
      sclk_drv[d] = ~sample_lvl[d];
      mosi = b;
      #40;
      sclk_drv[d] = sample_lvl[d];
      #40;
    end
    sclk_drv[d] = idle_lvl[d];
    #40;
  endtask

  // Load pulse; optionally ack exactly in the commit cycle (4th cycle after load)
  task automatic load_pulse(input logic ack_in_commit);
    load = 1'b1;
    #40;
    load = 1'b0;
    ack8 = ack_in_commit;
    #10;
    ack8 = 1'b0;
    #50;
  endtask

  logic [127:0] data;
  logic         v, o;
  logic [6:0]   cnt;
  int           d, fe0;
  logic [7:0]   w;

  initial begin
    vecs[0] = '{0, 128'hA5,  8,  1'b1, 7'd8,  128'hA5, 1'b1, 1'b0, 0};
    vecs[1] = '{0, 128'h7F,  7,  1'b0, 7'd7,  128'hA5, 1'b0, 1'b0, 1};
    vecs[2] = '{0, 128'h55,  9,  1'b0, 7'd9,  128'hA5, 1'b0, 1'b0, 1};
    vecs[3] = '{0, 128'hFF,  10, 1'b0, 7'd9,  128'hA5, 1'b0, 1'b0, 1};
    vecs[4] = '{0, 128'h00,  0,  1'b0, 7'd0,  128'hA5, 1'b0, 1'b0, 1};
    vecs[5] = '{0, 128'h11,  8,  1'b0, 7'd8,  128'h11, 1'b1, 1'b0, 0};
    vecs[6] = '{0, 128'h22,  8,  1'b0, 7'd8,  128'h22, 1'b1, 1'b1, 0};
    vecs[7] = '{1, 128'h0123456789ABCDEF, 64, 1'b0, 7'd64, 128'h0123456789ABCDEF, 1'b1, 1'b0, 0};
    vecs[8] = '{2, 128'h0123456789ABCDEF, 64, 1'b0, 7'd64, 128'h0123456789ABCDEF, 1'b1, 1'b0, 0};
    vecs[9] = '{3, 128'h0123456789ABCDEF, 64, 1'b0, 7'd64, 128'h0123456789ABCDEF, 1'b1, 1'b0, 0};

    #20 rst = 1'b0;
    #20;
    read_out(0, data, v, o, cnt);
    check("reset_data", data, 128'h0);
    check("reset_valid", 128'(v), 128'h0);
    check("reset_overrun", 128'(o), 128'h0);
    check("reset_bit_cnt", 128'(cnt), 128'h0);
    check("reset_frame_err", 128'(fe_cnt[0]), 128'h0);
    $display("reset: data %0h valid %0b overrun %0b bit_cnt %0d", data, v, o, cnt);

    for (int k = 0; k < 10; k++) begin
      d   = vecs[k].d;
      fe0 = fe_cnt[d];
      send_word(d, vecs[k].word, vecs[k].nbits);
      read_out(d, data, v, o, cnt);
      check($sformatf("vec%0d_bit_cnt", k), 128'(cnt), 128'(vecs[k].exp_cnt));
      load_pulse(1'b0);
      read_out(d, data, v, o, cnt);
      check($sformatf("vec%0d_data", k), data, vecs[k].exp_data);
      check($sformatf("vec%0d_valid", k), 128'(v), 128'(vecs[k].exp_valid));
      check($sformatf("vec%0d_overrun", k), 128'(o), 128'(vecs[k].exp_ovr));
      check($sformatf("vec%0d_frame_err_cycles", k), 128'(fe_cnt[d] - fe0), 128'(vecs[k].exp_fe));
      $display("vec %0d: dut %0d bits %0d -> data %0h valid %0b overrun %0b frame_err cycles %0d",
               k, d, vecs[k].nbits, data, v, o, fe_cnt[d] - fe0);
      if (vecs[k].ack_after) begin
        ack8 = 1'b1;
        #10;
        read_out(d, data, v, o, cnt);
        check($sformatf("vec%0d_ack_clears_valid", k), 128'(v), 128'h0);
        ack8 = 1'b0;
        $display("vec %0d: ack -> valid %0b", k, v);
      end
    end

    // Good frame while valid, ack in the commit cycle: overrun already set stays set
    fe0 = fe_cnt[0];
    send_word(0, 128'h33, 8);
    load_pulse(1'b1);
    read_out(0, data, v, o, cnt);
    check("ackcommit_data", data, 128'h33);
    check("ackcommit_valid", 128'(v), 128'h1);
    check("ackcommit_overrun", 128'(o), 128'h1);
    $display("ack-in-commit: data %0h valid %0b overrun %0b", data, v, o);

    // 8th sample edge and load edge reach the pins together
    w   = 8'hC3;
    fe0 = fe_cnt[0];
    for (int i = 0; i < 7; i++) begin
      sclk_drv[0] = 1'b0;
      mosi = w[7-i];
      #40;
      sclk_drv[0] = 1'b1;
      #40;
    end
    sclk_drv[0] = 1'b0;
    mosi = w[0];
    #40;
    sclk_drv[0] = 1'b1;
    load = 1'b1;
    #40;
    sclk_drv[0] = 1'b0;
    #40;
    load = 1'b0;
    #100;
    read_out(0, data, v, o, cnt);
    check("samecycle_data", data, 128'hC3);
    check("samecycle_valid", 128'(v), 128'h1);
    check("samecycle_frame_err_cycles", 128'(fe_cnt[0] - fe0), 128'h0);
    check("samecycle_bit_cnt", 128'(cnt), 128'h0);
    $display("same-cycle sample/commit: data %0h valid %0b bit_cnt %0d", data, v, cnt);
    ack8 = 1'b1;
    #10;
    ack8 = 1'b0;
    read_out(0, data, v, o, cnt);
    check("samecycle_ack_valid", 128'(v), 128'h0);

    // Asynchronous reset after 4 of 8 bits
    send_word(0, 128'h3C, 4);
    read_out(0, data, v, o, cnt);
    check("partial_bit_cnt", 128'(cnt), 128'h4);
    fe0 = fe_cnt[0];
    rst = 1'b1;
    #1;
    read_out(0, data, v, o, cnt);
    check("midreset_data", data, 128'h0);
    check("midreset_valid", 128'(v), 128'h0);
    check("midreset_overrun", 128'(o), 128'h0);
    check("midreset_bit_cnt", 128'(cnt), 128'h0);
    $display("reset mid-frame: data %0h valid %0b overrun %0b bit_cnt %0d", data, v, o, cnt);
    #9 rst = 1'b0;
    #20;

    // Full 0x3C frame after reset, with load-to-valid latency check
    send_word(0, 128'h3C, 8);
    load = 1'b1;
    #40;
    read_out(0, data, v, o, cnt);
    check("latency_valid_early", 128'(v), 128'h0);
    load = 1'b0;
    #10;
    read_out(0, data, v, o, cnt);
    check("latency_valid_on_time", 128'(v), 128'h1);
    check("post_reset_data", data, 128'h3C);
    #50;
    read_out(0, data, v, o, cnt);
    check("post_reset_frame_err_cycles", 128'(fe_cnt[0] - fe0), 128'h0);
    check("post_reset_overrun", 128'(o), 128'h0);
    $display("post-reset frame: data %0h valid %0b overrun %0b", data, v, o);

    // Ack in the commit cycle with overrun clear: no overrun, valid stays
    send_word(0, 128'h5A, 8);
    load_pulse(1'b1);
    read_out(0, data, v, o, cnt);
    check("ackcommit2_data", data, 128'h5A);
    check("ackcommit2_valid", 128'(v), 128'h1);
    check("ackcommit2_overrun", 128'(o), 128'h0);
    $display("ack-in-commit clean: data %0h valid %0b overrun %0b", data, v, o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
